alu_result_checker: RTL and testbench
=====================================

// Module: alu_result_checker
// PURPOSE
//  Hardware scoreboard for the 8-bit registered ALU. It records each operation
//  issued to the ALU (a, b, f) and computes the expected result. It queues that
//  result until the ALU's y comes back, then compares the two and keeps
//  pass/fail counts. It also captures the first mismatch.
//  Sits beside the ALU in self-test builds: the stimulus source drives both the
//  ALU and op_*; the ALU output feeds res_*.
// PARAMETERS
//  WIDTH        8   operand/result width
//  DEPTH        4   expected-result queue depth; power of 2, >=2
//  CNT_W        16  width of pass/fail counters
//  STOP_ON_ERR  1   1: halt on first mismatch; 0: keep counting
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-low
//  start      in   1      1-cycle pulse: clear state, enter RUN
//  op_valid   in   1      operation issued this cycle
//  op_a       in   WIDTH  operand a
//  op_b       in   WIDTH  operand b
//  op_f       in   3      opcode
//  op_ready   out  1      queue can accept (RUN && !full, or RUN && full && res_valid)
//  res_valid  in   1      ALU result present this cycle
//  res_y      in   WIDTH  ALU result
//  busy       out  1      state==RUN
//  halted     out  1      state==HALT
//  pass_cnt   out  CNT_W  matching results, saturating
//  fail_cnt   out  CNT_W  mismatching results, saturating
//  err_flag   out  1      a mismatch has been captured
//  unexp_res  out  1      res_valid seen with queue empty (protocol error)
//  err_op     out  3      opcode of first mismatch
//  err_exp    out  WIDTH  expected value of first mismatch
//  err_got    out  WIDTH  received value of first mismatch
// BEHAVIOUR
//  Opcodes (mod 2^WIDTH):
//  - 000 a+b; 001 a-b; 010 a&b; 011 a|b
//  - 100 a^b; 101 ~a; 110 a<<1; 111 a>>1 (logical)
//  Reset (rst==0 at edge): state IDLE, queue empty, all outputs 0.
//  FSM:
//  - IDLE: start -> RUN.
//  - RUN: start -> RUN (restart). unexp -> HALT. Mismatch && STOP_ON_ERR -> HALT.
//  - HALT: start -> RUN.
//  start (any state): flush queue; clear counters, err_*, err_flag, unexp_res.
//  start has priority over op/res in the same cycle; that cycle's op/res are dropped.
//  Push: op_valid && op_ready writes {f, expected} at the tail. Expected is
//  computed combinationally from op_*; 1-cycle write latency.
//  Pop: res_valid in RUN with queue non-empty. Compare head.expected to res_y in
//  the same cycle; counters update at that edge.
//  Push and pop in the same cycle: both happen, count unchanged. Allowed when full.
//  Same-cycle op_valid and res_valid with queue empty:
//  - unexp_res=1, go to HALT;
//  - the op is not pushed.
//  Mismatch:
//  - fail_cnt+1;
//  - if !err_flag, latch err_op/err_exp/err_got and set err_flag;
//  - later mismatches update only fail_cnt.
//  Counters saturate at 2^CNT_W-1. Pointers wrap modulo DEPTH.
//  Occupancy counter 0..DEPTH.
//  IDLE/HALT: op_ready=0; op_valid/res_valid ignored; outputs held.
//  A reset during RUN discards the queue and all counts.
// TESTING
//  1 start; a=00,b=FF, f=0..7 one per cycle; y returned 1 cycle later:
//    FF,01,00,FF,FF,FF,00,00 -> pass_cnt=8, fail_cnt=0, err_flag=0.
//  2 a=0F,b=01,f=000, y=11 -> fail_cnt=1, err_op=0, err_exp=10, err_got=11,
//    halted=1 (STOP_ON_ERR=1); op_ready=0 afterwards.
//  3 Issue DEPTH ops with no results -> op_ready=0. Assert op_valid together with
//    res_valid -> push accepted; after DEPTH more results pass_cnt=DEPTH+1.
//  4 res_valid with empty queue -> unexp_res=1, halted=1, counters unchanged.
//    Then start -> all cleared, busy=1.
//  5 STOP_ON_ERR=0: 3 mismatches (first exp=FE got=00) then 2 matches ->
//    fail_cnt=3, pass_cnt=2, err_exp=FE.
//  6 rst low for 1 cycle with 2 ops queued -> all outputs 0, IDLE; a later
//    res_valid is ignored.

Source files
------------

// File: rtl/alu_result_checker.sv
// alu_result_checker
//   Scoreboard for an 8-bit registered ALU. Every issued operation (op_*) has
//   its expected result computed and queued together with its opcode. Each
//   returned ALU result (res_*) is compared against the queue head. The block
//   keeps saturating pass/fail counts and captures the first mismatch.
// Ports
//   clk, rst        rising-edge clock, synchronous active-low reset
//   start           1-cycle pulse: flush queue, clear status, enter RUN
//   op_valid/op_a/op_b/op_f/op_ready   operation issue side
//   res_valid/res_y                    ALU result side
//   busy, halted                       RUN / HALT state flags
//   pass_cnt, fail_cnt                 saturating result counters
//   err_flag, err_op, err_exp, err_got first-mismatch capture
//   unexp_res                          result arrived with nothing queued
module alu_result_checker #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_valid,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       op_f,
  output logic             op_ready,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_y,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_flag,
  output logic             unexp_res,
  output logic [2:0]       err_op,
  output logic [WIDTH-1:0] err_exp,
  output logic [WIDTH-1:0] err_got
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]      FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  typedef struct packed {
    logic [2:0]       f;
    logic [WIDTH-1:0] exp;
  } entry_t;

  state_t           state;
  entry_t           mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      occ;
  logic [WIDTH-1:0] exp_y;
  entry_t           head;
  logic             run, empty, full, push, pop, unexp, mism;

  // Reference ALU; results wrap modulo 2^WIDTH.
  always_comb begin
    exp_y = '0;
    case (op_f)
      3'd0: exp_y = op_a + op_b;
      3'd1: exp_y = op_a - op_b;
      3'd2: exp_y = op_a & op_b;
      3'd3: exp_y = op_a | op_b;
      3'd4: exp_y = op_a ^ op_b;
      3'd5: exp_y = ~op_a;
      3'd6: exp_y = {op_a[WIDTH-2:0], 1'b0};
      3'd7: exp_y = {1'b0, op_a[WIDTH-1:1]};
      default: exp_y = '0;
    endcase
  end

  assign run      = (state == RUN);
  assign busy     = run;
  assign halted   = (state == HALT);
  assign empty    = (occ == '0);
  assign full     = (occ == FULL_OCC);
  // A same-cycle pop frees the slot, so a full queue still accepts.
  assign op_ready = run && (!full || res_valid);
  assign head     = mem[rd_ptr];

  // start wins: that cycle's op/res are dropped.
  assign unexp = run && !start && res_valid && empty;
  assign pop   = run && !start && res_valid && !empty;
  // An op paired with an unexpected result is not queued.
  assign push  = run && !start && op_valid && op_ready && !unexp;
  assign mism  = pop && (head.exp != res_y);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      err_flag  <= 1'b0;
      unexp_res <= 1'b0;
      err_op    <= '0;
      err_exp   <= '0;
      err_got   <= '0;
    end else if (start) begin
      state     <= RUN;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      err_flag  <= 1'b0;
      unexp_res <= 1'b0;
      err_op    <= '0;
      err_exp   <= '0;
      err_got   <= '0;
    end else if (run) begin
      if (push) begin
        mem[wr_ptr] <= '{f: op_f, exp: exp_y};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (mism) begin
          if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
          if (!err_flag) begin
            err_flag <= 1'b1;
            err_op   <= head.f;
            err_exp  <= head.exp;
            err_got  <= res_y;
          end
        end else if (pass_cnt != CNT_MAX) begin
          pass_cnt <= pass_cnt + 1'b1;
        end
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (unexp) begin
        unexp_res <= 1'b1;
        state     <= HALT;
      end else if (mism && STOP_ON_ERR) begin
        state <= HALT;
      end
    end
  end
endmodule

// File: tb/tb_alu_result_checker.sv
module tb_alu_result_checker;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, op_valid, res_valid;
  logic [7:0] op_a, op_b, res_y;
  logic [2:0] op_f;

  // dut0: halts on first mismatch, 16-bit counters.
  logic        rdy0, busy0, hlt0, ef0, ux0;
  logic [15:0] pc0, fc0;
  logic [2:0]  eo0;
  logic [7:0]  ee0, eg0;
  // dut1: keeps counting, 3-bit counters so saturation is reachable.
  logic        rdy1, busy1, hlt1, ef1, ux1;
  logic [2:0]  pc1, fc1;
  logic [2:0]  eo1;
  logic [7:0]  ee1, eg1;

  alu_result_checker #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(16), .STOP_ON_ERR(1'b1)) dut0 (
    .clk(clk), .rst(rst), .start(start), .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
    .op_f(op_f), .op_ready(rdy0), .res_valid(res_valid), .res_y(res_y), .busy(busy0),
    .halted(hlt0), .pass_cnt(pc0), .fail_cnt(fc0), .err_flag(ef0), .unexp_res(ux0),
    .err_op(eo0), .err_exp(ee0), .err_got(eg0));

  alu_result_checker #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(3), .STOP_ON_ERR(1'b0)) dut1 (
    .clk(clk), .rst(rst), .start(start), .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
    .op_f(op_f), .op_ready(rdy1), .res_valid(res_valid), .res_y(res_y), .busy(busy1),
    .halted(hlt1), .pass_cnt(pc1), .fail_cnt(fc1), .err_flag(ef1), .unexp_res(ux1),
    .err_op(eo1), .err_exp(ee1), .err_got(eg1));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic ready, busy, halted, errf, unexp;
    int   pass, fail, eop, eexp, egot;
  } exp_t;
  exp_t sb0[$];
  exp_t sb1[$];

  // Behavioural model: 0 idle, 1 run, 2 halt; queue as a shifting array.
  int mst[2], pass[2], fail[2], errf[2], unexp[2], eop[2], eexp[2], egot[2];
  int qe[2][DEPTH], qf[2][DEPTH], qn[2];
  int cmax[2] = '{65535, 7};
  int stop[2] = '{1, 0};
  bit arm = 1'b0;

  function automatic int alu(int a, int b, int f);
    case (f)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return 255 - a;
      6: return (a * 2) % 256;
      default: return a / 2;
    endcase
  endfunction

  task automatic cmp(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, got, want, $time);
    end
  endtask

  task automatic mclear(input int d);
    qn[d] = 0; pass[d] = 0; fail[d] = 0; errf[d] = 0; unexp[d] = 0;
    eop[d] = 0; eexp[d] = 0; egot[d] = 0;
  endtask

  task automatic mupd(input int d, input bit r, s, ov, input int a, b, f, input bit rv, input int y);
    int he, hf;
    bit rd;
    if (!r) begin mclear(d); mst[d] = 0; end
    else if (s) begin mclear(d); mst[d] = 1; end
    else if (mst[d] == 1) begin
      rd = (qn[d] < DEPTH) || rv;
      if (rv && qn[d] == 0) begin
        unexp[d] = 1; mst[d] = 2;
      end else begin
        if (rv) begin
          he = qe[d][0]; hf = qf[d][0];
          for (int k = 0; k < DEPTH-1; k++) begin qe[d][k] = qe[d][k+1]; qf[d][k] = qf[d][k+1]; end
          qn[d]--;
          if (he == y) pass[d] = (pass[d] < cmax[d]) ? pass[d] + 1 : cmax[d];
          else begin
            fail[d] = (fail[d] < cmax[d]) ? fail[d] + 1 : cmax[d];
            if (errf[d] == 0) begin errf[d] = 1; eop[d] = hf; eexp[d] = he; egot[d] = y; end
            if (stop[d] != 0) mst[d] = 2;
          end
        end
        if (ov && rd) begin qe[d][qn[d]] = alu(a, b, f); qf[d][qn[d]] = f; qn[d]++; end
      end
    end
  endtask

  task automatic cyc(input bit r, s, ov, input int a, b, f, input bit rv, input int y);
    exp_t e;
    @(posedge clk); #1;
    rst = r; start = s; op_valid = ov; op_a = 8'(a); op_b = 8'(b); op_f = 3'(f);
    res_valid = rv; res_y = 8'(y);
    for (int d = 0; d < 2; d++) begin
      e.ready = (mst[d] == 1) && ((qn[d] < DEPTH) || rv);
      e.busy = (mst[d] == 1); e.halted = (mst[d] == 2);
      e.errf = errf[d][0]; e.unexp = unexp[d][0];
      e.pass = pass[d]; e.fail = fail[d]; e.eop = eop[d]; e.eexp = eexp[d]; e.egot = egot[d];
      if (arm) begin if (d == 0) sb0.push_back(e); else sb1.push_back(e); end
      mupd(d, r, s, ov, a, b, f, rv, y);
    end
    arm = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic mon(input string p, input exp_t e, input logic rdy, bsy, hlt, ef, ux,
                     input logic [15:0] pc, fc, input logic [2:0] eo, input logic [7:0] ee, eg);
    cmp({p, ".op_ready"}, 32'(rdy), 32'(e.ready));
    cmp({p, ".busy"}, 32'(bsy), 32'(e.busy));
    cmp({p, ".halted"}, 32'(hlt), 32'(e.halted));
    cmp({p, ".err_flag"}, 32'(ef), 32'(e.errf));
    cmp({p, ".unexp_res"}, 32'(ux), 32'(e.unexp));
    cmp({p, ".pass_cnt"}, 32'(pc), e.pass);
    cmp({p, ".fail_cnt"}, 32'(fc), e.fail);
    cmp({p, ".err_op"}, 32'(eo), e.eop);
    cmp({p, ".err_exp"}, 32'(ee), e.eexp);
    cmp({p, ".err_got"}, 32'(eg), e.egot);
  endtask

  // Monitor: registered outputs mid-cycle reflect the model's pre-edge state.
  always @(negedge clk) begin
    exp_t e;
    if (sb0.size() > 0) begin
      e = sb0.pop_front();
      mon("d0", e, rdy0, busy0, hlt0, ef0, ux0, pc0, fc0, eo0, ee0, eg0);
    end
    if (sb1.size() > 0) begin
      e = sb1.pop_front();
      mon("d1", e, rdy1, busy1, hlt1, ef1, ux1, 16'(pc1), 16'(fc1), eo1, ee1, eg1);
    end
  end

  initial begin
    int ys1 [8] = '{8'hFF, 8'h01, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
    int ys5 [5] = '{8'h00, 8'h00, 8'h00, 8'hFE, 8'hFE};
    bit r, s, ov, rv;
    int y;
    rst = 0; start = 0; op_valid = 0; res_valid = 0; op_a = 0; op_b = 0; op_f = 0; res_y = 0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // 1: all eight opcodes, results one cycle behind
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++)
      cyc(1, 0, i < 8, 8'h00, 8'hFF, i, i > 0, (i > 0) ? ys1[i-1] : 0);
    idle(1); @(negedge clk);
    cmp("t1.pass_cnt", 32'(pc0), 8);
    cmp("t1.fail_cnt", 32'(fc0), 0);
    cmp("t1.sat_pass_cnt", 32'(pc1), 7);

    // 2: mismatch halts dut0
    cyc(1, 0, 1, 8'h0F, 8'h01, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 8'h11);
    idle(1); @(negedge clk);
    cmp("t2.fail_cnt", 32'(fc0), 1);
    cmp("t2.err_exp", 32'(ee0), 8'h10);
    cmp("t2.err_got", 32'(eg0), 8'h11);
    cmp("t2.halted", 32'(hlt0), 1);
    cmp("t2.op_ready", 32'(rdy0), 0);

    // 3: fill, then push+pop while full
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 1, i, 3, 0, 0, 0);
    cyc(1, 0, 1, 9, 9, 0, 0, 0);
    cyc(1, 0, 1, 5, 5, 0, 1, 3);
    for (int i = 1; i < DEPTH; i++) cyc(1, 0, 0, 0, 0, 0, 1, i + 3);
    cyc(1, 0, 0, 0, 0, 0, 1, 10);
    idle(1); @(negedge clk);
    cmp("t3.pass_cnt", 32'(pc0), DEPTH + 1);

    // 4: unexpected result, then restart
    cyc(1, 0, 1, 1, 1, 0, 1, 0);
    idle(1); @(negedge clk);
    cmp("t4.unexp_res", 32'(ux0), 1);
    cmp("t4.halted", 32'(hlt0), 1);
    cmp("t4.pass_cnt", 32'(pc0), DEPTH + 1);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    idle(1); @(negedge clk);
    cmp("t4.busy", 32'(busy0), 1);
    cmp("t4.cleared", 32'({ux0, ef0, pc0, fc0}), 0);

    // 5: keep-counting instance, 3 mismatches then 2 matches
    for (int i = 0; i < 6; i++)
      cyc(1, 0, i < 5, 8'h01, 0, 5, i > 0, (i > 0) ? ys5[i-1] : 0);
    idle(1); @(negedge clk);
    cmp("t5.fail_cnt", 32'(fc1), 3);
    cmp("t5.pass_cnt", 32'(pc1), 2);
    cmp("t5.err_exp", 32'(ee1), 8'hFE);
    cmp("t5.d0_fail_cnt", 32'(fc0), 1);

    // 6: reset with ops queued, later result ignored
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 2, 0, 0, 0);
    cyc(1, 0, 1, 3, 4, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 3);
    idle(1); @(negedge clk);
    cmp("t6.all_zero", 32'({busy0, hlt0, ux0, ef0, rdy0, pc0, fc0}), 0);

    // Random traffic
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom % 150) != 0;
      s  = (mst[0] != 1) ? (($urandom % 4) == 0) : (($urandom % 90) == 0);
      ov = $urandom % 2;
      rv = (qn[0] > 0) ? bit'($urandom % 2) : (($urandom % 30) == 0);
      y  = (qn[0] > 0 && ($urandom % 12) != 0) ? qe[0][0] : int'($urandom % 256);
      cyc(r, s, ov, $urandom % 256, $urandom % 256, $urandom % 8, rv, y);
    end
    idle(2); @(negedge clk); #1;
    if (sb0.size() != 0 || sb1.size() != 0) cmp("scoreboard_drain", 32'(sb0.size() + sb1.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
